// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one request/acknowledge memory bus between the fetch and load/store ports
module memory_arbiter #(
    parameter int BUS_ADDRESS_WIDTH = 32,
    parameter int BUS_DATA_WIDTH    = 32,
    parameter int MAX_DATA_STREAK   = 4,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetch_request,
    input  logic [BUS_ADDRESS_WIDTH-1:0] fetch_address,
    output logic                         fetch_ready,
    output logic [BUS_DATA_WIDTH-1:0]    fetch_read_data,
    output logic                         fetch_error,
    input  logic                         data_request,
    input  logic                         data_write_enable,
    input  logic [BUS_ADDRESS_WIDTH-1:0] data_address,
    input  logic [BUS_DATA_WIDTH-1:0]    data_write_data,
    output logic                         data_ready,
    output logic [BUS_DATA_WIDTH-1:0]    data_read_data,
    output logic                         data_error,
    output logic                         bus_request,
    output logic                         bus_write_enable,
    output logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
    output logic [BUS_DATA_WIDTH-1:0]    bus_write_data,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_read_data,
    input  logic                         bus_acknowledge,
    output logic                         grant_data
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                       state_q;
    logic [SW-1:0]                streak_q;
    logic [TW-1:0]                timer_q;
    logic                         grant_data_q, bus_request_q, bus_write_enable_q;
    logic [BUS_ADDRESS_WIDTH-1:0] bus_address_q;
    logic [BUS_DATA_WIDTH-1:0]    bus_write_data_q, fetch_read_data_q, data_read_data_q;
    logic                         fetch_ready_q, fetch_error_q, data_ready_q, data_error_q;

    // Data wins ties unless the fetch port has already waited through a full streak.
    logic                      pick_data, timed_out;
    logic [BUS_DATA_WIDTH-1:0] captured;
    always_comb begin
        pick_data = data_request && !(fetch_request && streak_q == STREAK_MAX);
        timed_out = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_LAST);
        captured  = (bus_acknowledge && !bus_write_enable_q) ? bus_read_data : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q            <= IDLE;
            streak_q           <= '0;
            timer_q            <= '0;
            grant_data_q       <= 1'b0;
            bus_request_q      <= 1'b0;
            bus_write_enable_q <= 1'b0;
            bus_address_q      <= '0;
            bus_write_data_q   <= '0;
            fetch_read_data_q  <= '0;
            data_read_data_q   <= '0;
            fetch_ready_q      <= 1'b0;
            fetch_error_q      <= 1'b0;
            data_ready_q       <= 1'b0;
            data_error_q       <= 1'b0;
        end else begin
            fetch_ready_q <= 1'b0;
            fetch_error_q <= 1'b0;
            data_ready_q  <= 1'b0;
            data_error_q  <= 1'b0;
            case (state_q)
                IDLE: if (fetch_request || data_request) begin
                    grant_data_q       <= pick_data;
                    bus_request_q      <= 1'b1;
                    bus_write_enable_q <= pick_data && data_write_enable;
                    bus_address_q      <= pick_data ? data_address : fetch_address;
                    bus_write_data_q   <= pick_data ? data_write_data : '0;
                    timer_q            <= '0;
                    streak_q           <= !pick_data ? '0 :
                                          (fetch_request && streak_q != STREAK_MAX) ? streak_q + 1'b1 : streak_q;
                    state_q            <= ACCESS;
                end
                ACCESS: if (bus_acknowledge || timed_out) begin
                    bus_request_q <= 1'b0;
                    state_q       <= RESPOND;
                    if (grant_data_q) begin
                        data_ready_q     <= 1'b1;
                        data_error_q     <= !bus_acknowledge;
                        data_read_data_q <= captured;
                    end else begin
                        fetch_ready_q     <= 1'b1;
                        fetch_error_q     <= !bus_acknowledge;
                        fetch_read_data_q <= captured;
                    end
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_ready      = fetch_ready_q;
    assign fetch_read_data  = fetch_read_data_q;
    assign fetch_error      = fetch_error_q;
    assign data_ready       = data_ready_q;
    assign data_read_data   = data_read_data_q;
    assign data_error       = data_error_q;
    assign bus_request      = bus_request_q;
    assign bus_write_enable = bus_write_enable_q;
    assign bus_address      = bus_address_q;
    assign bus_write_data   = bus_write_data_q;
    assign grant_data       = grant_data_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of arbitration, latency, streak guard, timeout and reset
module tb_memory_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_request = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_ready, fetch_error;
    logic [31:0] fetch_read_data;
    logic        data_request = 1'b0, data_write_enable = 1'b0;
    logic [31:0] data_address = '0, data_write_data = '0;
    logic        data_ready, data_error;
    logic [31:0] data_read_data;
    logic        bus_request, bus_write_enable;
    logic [31:0] bus_address, bus_write_data;
    logic [31:0] bus_read_data = '0;
    logic        bus_acknowledge = 1'b0;
    logic        grant_data;
    int checks = 0;
    int errors = 0;

    memory_arbiter dut (
        .clock(clock), .reset(reset),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready), .fetch_read_data(fetch_read_data), .fetch_error(fetch_error),
        .data_request(data_request), .data_write_enable(data_write_enable),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_ready(data_ready), .data_read_data(data_read_data), .data_error(data_error),
        .bus_request(bus_request), .bus_write_enable(bus_write_enable),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_acknowledge(bus_acknowledge),
        .grant_data(grant_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] order;
        order = 10'b0111101111;
        // Reset held with every stimulus active
        fetch_request = 1'b1; data_request = 1'b1; bus_acknowledge = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_bus_request", {31'd0, bus_request}, 32'd0);
            check("rst_readies", {30'd0, fetch_ready, data_ready}, 32'd0);
            check("rst_grant_err", {29'd0, grant_data, fetch_error, data_error}, 32'd0);
            check("rst_bus_address", bus_address, 32'd0);
        end
        fetch_request = 1'b0; data_request = 1'b0; bus_acknowledge = 1'b0; reset = 1'b1;
        tick();
        // Single fetch, minimum latency
        fetch_request = 1'b1; fetch_address = 32'h10;
        tick();
        check("f_bus_request", {31'd0, bus_request}, 32'd1);
        check("f_bus_address", bus_address, 32'h10);
        check("f_bus_we", {31'd0, bus_write_enable}, 32'd0);
        check("f_grant", {31'd0, grant_data}, 32'd0);
        bus_acknowledge = 1'b1; bus_read_data = 32'hDEADBEEF;
        tick();
        check("f_ready", {31'd0, fetch_ready}, 32'd1);
        check("f_rdata", fetch_read_data, 32'hDEADBEEF);
        check("f_error", {31'd0, fetch_error}, 32'd0);
        check("f_data_ready", {31'd0, data_ready}, 32'd0);
        check("f_bus_req_resp", {31'd0, bus_request}, 32'd0);
        bus_acknowledge = 1'b0; fetch_request = 1'b0;
        tick();
        check("f_ready_pulse", {31'd0, fetch_ready}, 32'd0);
        check("f_rdata_hold", fetch_read_data, 32'hDEADBEEF);
        // Store, acknowledged on the third ACCESS cycle
        data_request = 1'b1; data_write_enable = 1'b1; data_address = 32'h40; data_write_data = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_bus_request", {31'd0, bus_request}, 32'd1);
            check("s_bus_we", {31'd0, bus_write_enable}, 32'd1);
            check("s_bus_address", bus_address, 32'h40);
            check("s_bus_wdata", bus_write_data, 32'h1234);
            check("s_grant", {31'd0, grant_data}, 32'd1);
            check("s_no_ready", {31'd0, data_ready}, 32'd0);
        end
        bus_acknowledge = 1'b1; bus_read_data = 32'hFFFF;
        tick();
        check("s_ready", {31'd0, data_ready}, 32'd1);
        check("s_rdata_zero", data_read_data, 32'd0);
        check("s_error", {31'd0, data_error}, 32'd0);
        check("s_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        bus_acknowledge = 1'b0; data_request = 1'b0; data_write_enable = 1'b0;
        tick();
        // Both ports requesting continuously: D,D,D,D,F,D,D,D,D,F
        fetch_request = 1'b1; fetch_address = 32'h100;
        data_request = 1'b1; data_address = 32'h200;
        bus_acknowledge = 1'b1; bus_read_data = 32'hA5A5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a_grant", {31'd0, grant_data}, {31'd0, order[i]});
            check("a_bus_address", bus_address, order[i] ? 32'h200 : 32'h100);
            tick();
            check("a_data_ready", {31'd0, data_ready}, {31'd0, order[i]});
            check("a_fetch_ready", {31'd0, fetch_ready}, {31'd0, !order[i]});
            tick();
        end
        fetch_request = 1'b0; data_request = 1'b0; bus_acknowledge = 1'b0;
        check("a_data_rdata", data_read_data, 32'hA5A5);
        // Load that is never acknowledged times out after 16 ACCESS cycles
        data_request = 1'b1; data_address = 32'h80;
        tick();
        check("t_bus_request_first", {31'd0, bus_request}, 32'd1);
        repeat (15) tick();
        check("t_bus_request_16", {31'd0, bus_request}, 32'd1);
        check("t_no_ready_16", {31'd0, data_ready}, 32'd0);
        tick();
        check("t_ready", {31'd0, data_ready}, 32'd1);
        check("t_error", {31'd0, data_error}, 32'd1);
        check("t_rdata_zero", data_read_data, 32'd0);
        check("t_fetch_error", {31'd0, fetch_error}, 32'd0);
        check("t_bus_req_off", {31'd0, bus_request}, 32'd0);
        data_request = 1'b0;
        tick();
        check("t_error_pulse", {31'd0, data_error}, 32'd0);
        // Acknowledge in the 16th ACCESS cycle beats the timeout
        data_request = 1'b1;
        tick();
        repeat (15) tick();
        bus_acknowledge = 1'b1; bus_read_data = 32'h5555;
        tick();
        check("t16_ready", {31'd0, data_ready}, 32'd1);
        check("t16_error", {31'd0, data_error}, 32'd0);
        check("t16_rdata", data_read_data, 32'h5555);
        bus_acknowledge = 1'b0; data_request = 1'b0;
        tick();
        // Reset during ACCESS abandons the access
        fetch_request = 1'b1; fetch_address = 32'h20;
        tick();
        check("r_bus_request", {31'd0, bus_request}, 32'd1);
        reset = 1'b0; bus_acknowledge = 1'b1; bus_read_data = 32'h99;
        tick();
        check("r_bus_request_off", {31'd0, bus_request}, 32'd0);
        check("r_no_ready", {31'd0, fetch_ready}, 32'd0);
        check("r_rdata_cleared", fetch_read_data, 32'd0);
        reset = 1'b1; bus_acknowledge = 1'b0;
        tick();
        check("r_restart_req", {31'd0, bus_request}, 32'd1);
        check("r_restart_addr", bus_address, 32'h20);
        check("r_restart_no_ready", {31'd0, fetch_ready}, 32'd0);
        bus_acknowledge = 1'b1; bus_read_data = 32'h77;
        tick();
        check("r_ready", {31'd0, fetch_ready}, 32'd1);
        check("r_rdata", fetch_read_data, 32'h77);
        check("r_data_ready", {31'd0, data_ready}, 32'd0);
        fetch_request = 1'b0; bus_acknowledge = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
